// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Central stall/flush sequencer for the 5-stage 16-bit
//                pipeline. Merges load-use stalls, taken-branch flushes,
//                data-memory busy and halt requests into per-stage register
//                write enables and flush controls. A small FSM handles
//                multi-cycle memory waits (with timeout) and the halt drain.
//                Saturating stall/flush performance counters are kept.
//  Ports       : clk, rst_n (sync, active-low)
//                load_use_stall_i, branch_taken_i, mem_busy_i, halt_req_i,
//                resume_i                           -> event inputs
//                pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o
//                                                   -> register enables
//                if_id_flush_o, id_ex_flush_o       -> flush controls
//                state_o (RUN=0 MEM_WAIT=1 DRAIN=2 HALTED=3), mem_error_o,
//                stall_count_o, flush_count_o       -> status / counters
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_use_stall_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_busy_i,
    input  logic                 halt_req_i,
    input  logic                 resume_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 id_ex_write_o,
    output logic                 ex_mem_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic [1:0]           state_o,
    output logic                 mem_error_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    localparam int c_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_MAX = c_DRAIN_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [c_WAIT_W-1:0]    wait_q, wait_d;
    logic [c_DRAIN_W-1:0]   drain_q, drain_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   stall_q, flush_q;

    logic w_pc_write, w_if_id_write, w_id_ex_write, w_ex_mem_write;
    logic w_if_id_flush, w_id_ex_flush;
    logic w_run_eval;   // apply the normal RUN event priorities this cycle
    logic w_flush_inc;
    logic w_stall_inc;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        drain_d        = drain_q;
        err_d          = err_q;
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_ex_mem_write = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_run_eval     = 1'b0;
        w_flush_inc    = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mem_busy_i) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = c_WAIT_W'(1);
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_busy_i) begin
                    if (wait_q == c_WAIT_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        wait_d = wait_q + c_WAIT_W'(1);
                    end
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            S_DRAIN: begin
                // Memory busy freezes the drain in place; no timeout here.
                if (!mem_busy_i) begin
                    w_if_id_write  = 1'b1;
                    w_id_ex_write  = 1'b1;
                    w_ex_mem_write = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    if (drain_q == c_DRAIN_MAX) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q + c_DRAIN_W'(1);
                    end
                end
            end
            default: begin
                if (resume_i && !err_q) begin
                    state_d = S_RUN;
                end
            end
        endcase

        if (w_run_eval) begin
            state_d        = S_RUN;
            w_pc_write     = 1'b1;
            w_if_id_write  = 1'b1;
            w_id_ex_write  = 1'b1;
            w_ex_mem_write = 1'b1;
            if (halt_req_i) begin
                // Halt wins over a same-cycle branch; the branch is dropped.
                w_pc_write    = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                state_d       = S_DRAIN;
                drain_d       = c_DRAIN_W'(1);
            end else if (branch_taken_i) begin
                // Flushing the younger stages makes any load-use stall moot.
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_flush_inc   = 1'b1;
            end else if (load_use_stall_i) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_id_ex_flush = 1'b1;
            end
        end

        // Hold everything quiet while reset is asserted.
        if (!rst_n) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_if_id_flush  = 1'b0;
            w_id_ex_flush  = 1'b0;
        end
    end

    assign w_stall_inc = !w_pc_write && (state_q != S_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            if (w_stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (w_flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_WIDTH'(1);
            end
        end
    end

    assign pc_write_o     = w_pc_write;
    assign if_id_write_o  = w_if_id_write;
    assign id_ex_write_o  = w_id_ex_write;
    assign ex_mem_write_o = w_ex_mem_write;
    assign if_id_flush_o  = w_if_id_flush;
    assign id_ex_flush_o  = w_id_ex_flush;
    assign state_o        = state_q;
    assign mem_error_o    = err_q;
    assign stall_count_o  = stall_q;
    assign flush_count_o  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Directed-vector bench for pipeline_stall_controller. A
//                default instance and a CNT_WIDTH=4 instance share stimulus;
//                expected values are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_controller;

    logic clk;
    logic rst_n;
    logic lu, br, mb, hr, rs;

    logic        pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, merr;
    logic [1:0]  st;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_w, s_ifid_w, s_idex_w, s_exmem_w, s_ifid_f, s_idex_f, s_merr;
    logic [1:0]  s_st;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [3:0]  en;
    logic [1:0]  fl;
    assign en = {pc_w, ifid_w, idex_w, exmem_w};
    assign fl = {ifid_f, idex_f};

    int n_vec;
    int n_err;

    pipeline_stall_controller u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (lu),
        .branch_taken_i   (br),
        .mem_busy_i       (mb),
        .halt_req_i       (hr),
        .resume_i         (rs),
        .pc_write_o       (pc_w),
        .if_id_write_o    (ifid_w),
        .id_ex_write_o    (idex_w),
        .ex_mem_write_o   (exmem_w),
        .if_id_flush_o    (ifid_f),
        .id_ex_flush_o    (idex_f),
        .state_o          (st),
        .mem_error_o      (merr),
        .stall_count_o    (stall_cnt),
        .flush_count_o    (flush_cnt)
    );

    pipeline_stall_controller #(.CNT_WIDTH(4)) u_dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (lu),
        .branch_taken_i   (br),
        .mem_busy_i       (mb),
        .halt_req_i       (hr),
        .resume_i         (rs),
        .pc_write_o       (s_pc_w),
        .if_id_write_o    (s_ifid_w),
        .id_ex_write_o    (s_idex_w),
        .ex_mem_write_o   (s_exmem_w),
        .if_id_flush_o    (s_ifid_f),
        .id_ex_flush_o    (s_idex_f),
        .state_o          (s_st),
        .mem_error_o      (s_merr),
        .stall_count_o    (s_stall_cnt),
        .flush_count_o    (s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are applied 1 time unit after an edge; combinational outputs
    // are sampled at the falling edge.
    task automatic half();
        #4;
    endtask

    task automatic set_in(input logic l, input logic b, input logic m, input logic h, input logic r);
        lu = l; br = b; mb = m; hr = h; rs = r;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);

        // Reset held for two edges
        tick(); tick();
        half();
        check_val("rst_en", 32'(en), 32'h0);
        check_val("rst_fl", 32'(fl), 32'h0);
        rst_n = 1'b1;
        #1;
        check_val("rel_state", 32'(st), 32'd0);
        check_val("rel_stall", 32'(stall_cnt), 32'd0);
        check_val("rel_flush", 32'(flush_cnt), 32'd0);
        check_val("rel_en", 32'(en), 32'hF);
        check_val("rel_fl", 32'(fl), 32'h0);
        tick();

        // Load-use stall
        set_in(1, 0, 0, 0, 0); half();
        check_val("lu_en", 32'(en), 32'h3);
        check_val("lu_fl", 32'(fl), 32'h1);
        tick();
        check_val("lu_stall", 32'(stall_cnt), 32'd1);
        set_in(0, 0, 0, 0, 0); half();
        check_val("lu_after_en", 32'(en), 32'hF);
        tick();

        // Branch together with load-use: branch wins
        set_in(1, 1, 0, 0, 0); half();
        check_val("br_en", 32'(en), 32'hF);
        check_val("br_fl", 32'(fl), 32'h3);
        tick();
        check_val("br_flush", 32'(flush_cnt), 32'd1);
        check_val("br_stall", 32'(stall_cnt), 32'd1);

        // Memory busy for 4 cycles
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 0, 0); half();
            check_val("mb_en", 32'(en), 32'h0);
            check_val("mb_fl", 32'(fl), 32'h0);
            tick();
            check_val("mb_state", 32'(st), 32'd1);
        end
        set_in(0, 0, 0, 0, 0); half();
        check_val("mb_rel_en", 32'(en), 32'hF);
        tick();
        check_val("mb_rel_state", 32'(st), 32'd0);
        check_val("mb_stall", 32'(stall_cnt), 32'd5);

        // Branch evaluated in MEM_WAIT on the cycle busy drops
        set_in(0, 0, 1, 0, 0); half(); tick();
        check_val("mwb_state", 32'(st), 32'd1);
        set_in(0, 1, 0, 0, 0); half();
        check_val("mwb_en", 32'(en), 32'hF);
        check_val("mwb_fl", 32'(fl), 32'h3);
        tick();
        check_val("mwb_state2", 32'(st), 32'd0);
        check_val("mwb_flush", 32'(flush_cnt), 32'd2);
        check_val("mwb_stall", 32'(stall_cnt), 32'd6);

        // Halt and drain, with a 2-cycle memory busy inside the drain
        set_in(0, 0, 0, 1, 0); half();
        check_val("hlt_en", 32'(en), 32'h7);
        check_val("hlt_fl", 32'(fl), 32'h3);
        tick();
        check_val("hlt_state", 32'(st), 32'd2);
        set_in(0, 0, 0, 0, 0); half();
        check_val("dr1_en", 32'(en), 32'h7);
        tick();
        check_val("dr1_state", 32'(st), 32'd2);
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, 0, 0); half();
            check_val("drb_en", 32'(en), 32'h0);
            check_val("drb_fl", 32'(fl), 32'h0);
            tick();
            check_val("drb_state", 32'(st), 32'd2);
        end
        set_in(0, 1, 0, 0, 0); half();
        check_val("dr2_en", 32'(en), 32'h7);
        check_val("dr2_fl", 32'(fl), 32'h3);
        tick();
        check_val("dr2_state", 32'(st), 32'd2);
        check_val("dr2_flush", 32'(flush_cnt), 32'd2);
        set_in(0, 0, 0, 0, 0); half(); tick();
        check_val("dr3_state", 32'(st), 32'd3);
        check_val("dr_stall", 32'(stall_cnt), 32'd12);

        // HALTED, then resume
        half();
        check_val("hal_en", 32'(en), 32'h0);
        tick();
        check_val("hal_state", 32'(st), 32'd3);
        check_val("hal_stall", 32'(stall_cnt), 32'd12);
        set_in(0, 0, 0, 0, 1); half();
        check_val("res_en", 32'(en), 32'h0);
        tick();
        check_val("res_state", 32'(st), 32'd0);
        set_in(0, 0, 0, 0, 0); half();
        check_val("res_after_en", 32'(en), 32'hF);
        tick();

        // Memory timeout: 16 busy cycles reach HALTED with mem_error
        set_in(0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        check_val("to15_state", 32'(st), 32'd1);
        check_val("to15_err", 32'(merr), 32'd0);
        tick();
        check_val("to16_state", 32'(st), 32'd3);
        check_val("to16_err", 32'(merr), 32'd1);
        check_val("to_stall", 32'(stall_cnt), 32'd28);
        set_in(0, 0, 0, 0, 1); half();
        check_val("to_res_en", 32'(en), 32'h0);
        tick();
        check_val("to_res_state", 32'(st), 32'd3);
        check_val("to_res_err", 32'(merr), 32'd1);

        // Reset clears the sticky error; then saturation run
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("rst2_state", 32'(st), 32'd0);
        check_val("rst2_err", 32'(merr), 32'd0);
        check_val("rst2_stall", 32'(stall_cnt), 32'd0);
        check_val("rst2_flush", 32'(flush_cnt), 32'd0);
        check_val("rst2_sat", 32'(s_stall_cnt), 32'd0);
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        check_val("sat15_main", 32'(stall_cnt), 32'd15);
        check_val("sat15_sat", 32'(s_stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        check_val("sat20_main", 32'(stall_cnt), 32'd20);
        check_val("sat20_sat", 32'(s_stall_cnt), 32'd15);
        set_in(0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Combines the load-use stall from the hazard detection unit, the taken-branch flush from EX, the data-memory busy signal from MEM, and the halt request from WB.
- Produces pipeline-register write enables and flush controls for each cycle.
- Runs a small FSM for multi-cycle memory waits (with timeout) and the halt drain, plus saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive mem_busy cycles before error.
- DRAIN_CYCLES, 3: bubble cycles inserted after halt_req before HALTED.
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_use_stall  in  1  from hazard detection.
- branch_taken  in  1  EX-stage branch resolved taken.
- mem_busy  in  1  data memory not ready this cycle.
- halt_req  in  1  HLT instruction in WB.
- resume  in  1  leave HALTED.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- ex_mem_write  out  1  EX/MEM and MEM/WB register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to bubble.
- state  out  2  RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3.
- mem_error  out  1  sticky memory timeout flag.
- stall_count  out  CNT_WIDTH  cycles with pc_write=0 outside HALTED.
- flush_count  out  CNT_WIDTH  branch flushes taken.

Behaviour:
Reset and output style
- Reset (rst_n=0 at a clock edge): state=RUN, mem_error=0, counters=0, wait and drain counters=0.
- While rst_n=0, all enables=0 and flushes=0.
- Control outputs are combinational from state and inputs (zero latency). state, mem_error and the counters are registered.
- Default (RUN, no events): all four enables=1, both flushes=0.

Priority in RUN, highest first
1. mem_busy: all enables=0, flushes=0. Next state MEM_WAIT, wait counter=1.
2. halt_req: pc_write=0, if_id_flush=1, id_ex_flush=1, other enables=1. Next state DRAIN, drain counter=1. A simultaneous branch_taken is discarded.
3. branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1. flush_count+1. Any simultaneous load_use_stall is ignored.
4. load_use_stall: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1.

MEM_WAIT
- mem_busy=1: freeze (all enables 0), wait counter+1.
  - If the wait counter already equals MEM_TIMEOUT: mem_error<=1, next HALTED.
- mem_busy=0: outputs evaluated exactly as RUN priorities 2-4 in the same cycle. Next state follows those rules, else RUN.

DRAIN
- pc_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_write=1. Branch and load-use inputs are ignored.
- mem_busy=1 freezes all enables and holds the drain counter; the state does not go to MEM_WAIT and no timeout applies.
- When the drain counter = DRAIN_CYCLES, next state is HALTED; otherwise the counter increments.

HALTED
- All enables=0, flushes=0.
- resume=1 with mem_error=0: next RUN, enables resume the following cycle.
- resume is ignored while mem_error=1. Only reset clears mem_error.

Counters
- stall_count increments each cycle pc_write=0 and state≠HALTED.
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release with no events → state=0, counters=0, enables=1111, flushes=00.
- Load-use: load_use_stall=1 for 1 cycle → that cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1; next cycle all enables=1.
- Branch and load-use together: branch_taken=1 and load_use_stall=1 in one cycle → pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_count=0.
- Memory wait and timeout:
  - mem_busy=1 for 4 cycles → 4 frozen cycles, stall_count=4, return to RUN.
  - mem_busy held 16+ cycles (MEM_TIMEOUT=15) → mem_error=1, state=3. A subsequent resume=1 leaves state=3.
- Halt drain: halt_req pulse → 3 bubble cycles (state=2), then state=3. resume=1 → state=0 and enables=1111 next cycle. mem_busy=1 during drain extends drain by the busy length.
- Saturation: run with CNT_WIDTH=4 and 20 load-use stalls → stall_count=15, held.
